// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions used by the immediate generator and the instruction
// encoder: major-opcode constants (opcode[6:2]), the instruction format
// enumeration, the canonical NOP, and small classification helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

    // Major opcode field, opcode[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic fmt_e opc_to_fmt(input logic [4:0] opc);
        case (opc)
            OPC_OP:                        return FMT_R;
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: return FMT_I;
            OPC_STORE:                     return FMT_S;
            OPC_BRANCH:                    return FMT_B;
            OPC_LUI:                       return FMT_U;
            OPC_JAL:                       return FMT_J;
            default:                       return FMT_ILL;
        endcase
    endfunction

    // True when v, read as signed, is representable in 'bits' signed bits:
    // everything from bit bits-1 upward must be a pure sign extension.
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic signed [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// -----------------------------------------------------------------------------
// instr_pack
// Combinational RV32I field packer. Places already-validated fields into the
// 32-bit instruction word according to the format; FMT_ILL yields the NOP.
// Ports:
//   fmt_i      in   fmt_e  instruction format (FMT_ILL -> NOP)
//   opcode_i   in   7      full opcode, copied to bits [6:0]
//   rd_i       in   5      destination register
//   rs1_i      in   5      source register 1
//   rs2_i      in   5      source register 2
//   funct3_i   in   3      funct3
//   funct7_i   in   7      funct7
//   imm_i      in   32     byte immediate
//   instr_o    out  32     packed instruction
// -----------------------------------------------------------------------------
module instr_pack
    import riscv_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o
);

    always_comb begin
        instr_o = NOP_INSTR;
        case (fmt_i)
            FMT_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                              imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: instr_o = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                              rd_i, opcode_i};
            default: instr_o = NOP_INSTR;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Packs decoded RV32I fields into instruction words for the IMEM loader /
// self-test path. Two-stage valid/ready pipeline: stage 1 classifies the
// opcode and range-checks the immediate, stage 2 packs the word. Illegal
// requests come out as a NOP with err_o set. Each delivered beat carries a
// running byte address (step 4, wraps) and illegal beats are counted.
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_ni       in   1       asynchronous active-low reset
//   clr_i        in   1       sync clear: flush pipeline, zero address/counter
//   in_valid_i   in   1       request valid
//   in_ready_o   out  1       request accepted when valid & ready
//   opcode_i     in   7       opcode ([6:2] format, [1:0] copied)
//   rd_i/rs1_i/rs2_i in 5     register indices
//   funct3_i     in   3       funct3
//   funct7_i     in   7       funct7 (R-type)
//   imm_i        in   32      signed byte immediate
//   out_valid_o  out  1       output beat valid
//   out_ready_i  in   1       consumer ready
//   instr_o      out  32      encoded instruction
//   addr_o       out  ADDR_W  byte address of this beat
//   err_o        out  1       beat was illegal (instr_o = NOP)
//   err_cnt_o    out  CNT_W   saturating count of delivered illegal beats
// -----------------------------------------------------------------------------
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    function automatic logic imm_legal(input fmt_e f, input logic [31:0] imm);
        case (f)
            FMT_R:        return 1'b1;
            FMT_I, FMT_S: return fits_signed(imm, 12);
            FMT_B:        return fits_signed(imm, 13) && !imm[0];
            FMT_U:        return imm[11:0] == 12'd0;
            FMT_J:        return fits_signed(imm, 21) && !imm[0];
            default:      return 1'b0;
        endcase
    endfunction

    // Stage 1 registers
    logic        s1_valid_q, s1_valid_d;
    fmt_e        s1_fmt_q;
    logic [6:0]  s1_op_q;
    logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]  s1_f3_q;
    logic [6:0]  s1_f7_q;
    logic [31:0] s1_imm_q;

    // Stage 2 registers
    logic              s2_valid_q, s2_valid_d;
    logic [31:0]       instr_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic        s2_ready, in_ready, in_fire, s1_adv, out_fire;
    fmt_e        in_fmt, cls_fmt;
    logic [31:0] pack_instr;

    always_comb begin
        cls_fmt = opc_to_fmt(opcode_i[6:2]);
        in_fmt  = imm_legal(cls_fmt, imm_i) ? cls_fmt : FMT_ILL;
    end

    always_comb begin
        s2_ready   = ~s2_valid_q | out_ready_i;
        in_ready   = ~clr_i & (~s1_valid_q | s2_ready);
        in_fire    = in_valid_i & in_ready;
        s1_adv     = s1_valid_q & s2_ready & ~clr_i;
        out_fire   = s2_valid_q & out_ready_i & ~clr_i;

        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        if (clr_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            addr_d     = '0;
            cnt_d      = '0;
        end else begin
            // s1 empties when its beat moves on, refills on an accept
            if (in_fire)       s1_valid_d = 1'b1;
            else if (s2_ready) s1_valid_d = 1'b0;
            if (s2_ready)      s2_valid_d = s1_valid_q;
            if (out_fire) begin
                addr_d = addr_q + ADDR_W'(4);
                if (err_q && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // ---- stage 1: classify + range check ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= FMT_ILL;
            s1_op_q    <= '0;
            s1_rd_q    <= '0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_f3_q    <= '0;
            s1_f7_q    <= '0;
            s1_imm_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_fmt_q <= in_fmt;
                s1_op_q  <= opcode_i;
                s1_rd_q  <= rd_i;
                s1_rs1_q <= rs1_i;
                s1_rs2_q <= rs2_i;
                s1_f3_q  <= funct3_i;
                s1_f7_q  <= funct7_i;
                s1_imm_q <= imm_i;
            end
        end
    end

    instr_pack u_pack (
        .fmt_i    (s1_fmt_q),
        .opcode_i (s1_op_q),
        .rd_i     (s1_rd_q),
        .rs1_i    (s1_rs1_q),
        .rs2_i    (s1_rs2_q),
        .funct3_i (s1_f3_q),
        .funct7_i (s1_f7_q),
        .imm_i    (s1_imm_q),
        .instr_o  (pack_instr)
    );

    // ---- stage 2: packed word, address and error counter ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            if (s1_adv) begin
                instr_q <= pack_instr;
                err_q   <= (s1_fmt_q == FMT_ILL);
            end
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = s2_valid_q;
    assign instr_o     = instr_q;
    assign addr_o      = addr_q;
    assign err_o       = err_q;
    assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clr_i = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [6:0]        opcode_i = '0;
    logic [4:0]        rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [2:0]        funct3_i = '0;
    logic [6:0]        funct7_i = '0;
    logic [31:0]       imm_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] addr_o;
    logic              err_o;
    logic [CNT_W-1:0]  err_cnt_o;

    instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .instr_o     (instr_o),
        .addr_o      (addr_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_acc    = 0;

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake, and checks
    // that a stalled beat does not change while it waits.
    logic        stall_prev = 1'b0;
    logic [36:0] held = '0;
    always @(negedge clk_i) begin
        if (rst_ni && !clr_i && out_valid_o) begin
            if (stall_prev)
                chk("stall_hold", {27'd0, instr_o, addr_o, err_o}, {27'd0, held});
            if (out_ready_i) begin
                stall_prev = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(instr_o), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("instr", 64'(instr_o), 64'(e.instr));
                    chk("addr",  64'(addr_o),  64'(e.addr));
                    chk("err",   64'(err_o),   64'(e.err));
                end
            end else begin
                stall_prev = 1'b1;
                held = {instr_o, addr_o, err_o};
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] e_instr,
                        input logic [ADDR_W-1:0] e_addr, input logic e_err);
        int t;
        exp_t e;
        t = 0;
        in_valid_i = 1'b1;
        opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        forever begin
            @(negedge clk_i);
            if (in_ready_o) break;
            t++;
            if (t > 50) break;
        end
        if (t > 50) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            e.instr = e_instr; e.addr = e_addr; e.err = e_err;
            sb.push_back(e);
            n_acc++;
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic clear();
        drain();
        clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_instr",     64'(instr_o),     64'd0);
        chk("rst_addr",      64'(addr_o),      64'd0);
        chk("rst_err",       64'(err_o),       64'd0);
        chk("rst_err_cnt",   64'(err_cnt_o),   64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("in_ready_idle", 64'(in_ready_o), 64'd1);

        // 1: addi x1,x0,5 with two-cycle latency
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 4'd0, 1'b0);
        // send returned one cycle after the accept edge: not out yet
        chk("latency_n1", 64'(out_valid_o), 64'd0);
        @(posedge clk_i); #1;
        chk("latency_n2", 64'(out_valid_o), 64'd1);
        clear();

        // 2: back-to-back beq / lui / jal
        send(OP_BEQ, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE208CE3, 4'd0, 1'b0);
        send(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h123452B7, 4'd4, 1'b0);
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h001000EF, 4'd8, 1'b0);
        clear();

        // 3: illegal immediates become flagged NOPs
        send(OP_BEQ,  5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,    32'h00000013, 4'd0, 1'b1);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h00000013, 4'd4, 1'b1);
        drain();
        chk("err_cnt_2", 64'(err_cnt_o), 64'd2);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h80000093, 4'd8, 1'b0);
        send(OP_LUI,  5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h00000013, 4'd12, 1'b1);
        send(OP_BAD,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'h00000013, 4'd0, 1'b1);
        drain();
        chk("err_cnt_4", 64'(err_cnt_o), 64'd4);
        clear();
        chk("clr_err_cnt", 64'(err_cnt_o), 64'd0);

        // 4: backpressure for 4 cycles while 3 requests are offered
        out_ready_i = 1'b0;
        n_acc = 0;
        fork
            begin
                send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 4'd0, 1'b0);
                send(OP_ADD,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 4'd4, 1'b0);
                send(OP_SW,   5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 4'd8, 1'b0);
            end
            begin
                repeat (4) @(posedge clk_i);
                #1;
                chk("stall_accepts",  64'(n_acc),      64'd2);
                chk("stall_in_ready", 64'(in_ready_o), 64'd0);
                out_ready_i = 1'b1;
            end
        join
        clear();

        // 5: address wrap at 2**ADDR_W
        send(OP_ADD,  5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3, 4'd0,  1'b0);
        send(OP_SW,   5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423, 4'd4,  1'b0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00500093, 4'd8,  1'b0);
        send(OP_LUI,  5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h123452B7, 4'd12, 1'b0);
        send(OP_JAL,  5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h001000EF, 4'd0,  1'b0);
        clear();

        // 6a: async reset with two beats in flight
        send(OP_BAD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000013, 4'd0, 1'b1);
        drain();
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 4'd4, 1'b0);
        send(OP_ADDI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h00600113, 4'd8, 1'b0);
        #1;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        chk("rst6_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst6_addr",      64'(addr_o),      64'd0);
        chk("rst6_err_cnt",   64'(err_cnt_o),   64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst6_no_partial", 64'(out_valid_o), 64'd0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 4'd0, 1'b0);
        drain();

        // 6b: sync clear with two beats in flight
        send(OP_BAD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h00000013, 4'd4, 1'b1);
        drain();
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 4'd8, 1'b0);
        send(OP_ADDI, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h00600113, 4'd12, 1'b0);
        clr_i = 1'b1;
        in_valid_i = 1'b1;
        sb.delete();
        #1;
        chk("clr_in_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk_i); #1;
        clr_i = 1'b0;
        in_valid_i = 1'b0;
        chk("clr6_out_valid", 64'(out_valid_o), 64'd0);
        chk("clr6_addr",      64'(addr_o),      64'd0);
        chk("clr6_err_cnt",   64'(err_cnt_o),   64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("clr6_no_partial", 64'(out_valid_o), 64'd0);
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 4'd0, 1'b0);
        drain();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
